usb_bus_slave: RTL

USB_BUS_SLAVE -- requirements
Module: usb_bus_slave

---
 rtl/usb_bus_pkg.sv | 17 +
 rtl/usb_edge_det.sv | 40 ++++
 rtl/usb_bus_slave.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/usb_bus_pkg.sv
// usb_bus_pkg: shared constants and FSM state encoding for the USB bus slave.
//   ADDR_WIDTH_DEF   - default host address width
//   BYTECNT_SIZE_DEF - default number of low address bits selecting a byte
//   bus_state_e      - bus-slave FSM state encoding
package usb_bus_pkg;

  localparam int ADDR_WIDTH_DEF   = 21;
  localparam int BYTECNT_SIZE_DEF = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_ERR   = 2'd3
  } bus_state_e;

endpackage

// File: rtl/usb_edge_det.sv
// usb_edge_det: previous-cycle copies of the sampled cen, wrn and trigger.
// Ports:
//   usb_clk, reset_i        - clock, async active-high reset
//   cen_s, wrn_s, trig_s    - stage-1 sampled strobes / trigger
//   cen_rise                - sampled cen went 0->1 this cycle
//   wrn_prev                - sampled wrn from the previous cycle
//   trig_rise               - sampled trigger went 0->1 this cycle
module usb_edge_det (
  input  logic usb_clk,
  input  logic reset_i,
  input  logic cen_s,
  input  logic wrn_s,
  input  logic trig_s,
  output logic cen_rise,
  output logic wrn_prev,
  output logic trig_rise
);

  logic cen_d;
  logic wrn_d;
  logic trig_d;

  // Strobes preset high and trigger low so no edge appears right after reset.
  always_ff @(posedge usb_clk or posedge reset_i) begin
    if (reset_i) begin
      cen_d  <= 1'b1;
      wrn_d  <= 1'b1;
      trig_d <= 1'b0;
    end else begin
      cen_d  <= cen_s;
      wrn_d  <= wrn_s;
      trig_d <= trig_s;
    end
  end

  assign cen_rise  = cen_s & ~cen_d;
  assign wrn_prev  = wrn_d;
  assign trig_rise = trig_s & ~trig_d;

endmodule

// File: rtl/usb_bus_slave.sv
// usb_bus_slave: asynchronous host bus (cen/rdn/wrn) to register-file bridge.
// All pad inputs are registered once before use; every output is registered.
// Ports:
//   usb_clk, reset_i                  - clock, async active-high reset
//   usb_addr/usb_din/usb_rdn/usb_wrn/usb_cen/usb_trigger - host pad inputs
//   usb_dout, usb_isout               - read data and pad output enable
//   reg_address, reg_bytecnt          - register / byte select
//   reg_datao, reg_datai              - write data out, read data in
//   reg_read, reg_write, reg_addrvalid - register-file handshake
//   trig_pulse                        - one-cycle pulse per trigger rise
//   protocol_err                      - sticky flag, cen/rdn/wrn all low
//
// state | meaning
// IDLE  | no transfer; wait for cen low with rdn or wrn low
// WRITE | write in progress; data/address latched, strobe on cen rise
// READ  | read in progress; pad driven, usb_dout follows reg_datai
// ERR   | rdn and wrn both low under cen; all strobes suppressed
module usb_bus_slave
  import usb_bus_pkg::*;
#(
  parameter int pADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int pBYTECNT_SIZE = BYTECNT_SIZE_DEF
) (
  input  logic                               usb_clk,
  input  logic                               reset_i,
  input  logic [pADDR_WIDTH-1:0]             usb_addr,
  input  logic [7:0]                         usb_din,
  output logic [7:0]                         usb_dout,
  output logic                               usb_isout,
  input  logic                               usb_rdn,
  input  logic                               usb_wrn,
  input  logic                               usb_cen,
  input  logic                               usb_trigger,
  output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
  output logic [pBYTECNT_SIZE-1:0]           reg_bytecnt,
  output logic [7:0]                         reg_datao,
  input  logic [7:0]                         reg_datai,
  output logic                               reg_read,
  output logic                               reg_write,
  output logic                               reg_addrvalid,
  output logic                               trig_pulse,
  output logic                               protocol_err
);

  logic [pADDR_WIDTH-1:0] s_addr;
  logic [7:0]             s_din;
  logic                   s_rdn;
  logic                   s_wrn;
  logic                   s_cen;
  logic                   s_trig;

  logic cen_rise;
  logic wrn_prev;
  logic trig_rise;

  bus_state_e state;
  bus_state_e state_nxt;
  logic       err_cond;
  logic       wr_fire;

  always_ff @(posedge usb_clk or posedge reset_i) begin
    if (reset_i) begin
      s_addr <= '0;
      s_din  <= '0;
      s_rdn  <= 1'b1;
      s_wrn  <= 1'b1;
      s_cen  <= 1'b1;
      s_trig <= 1'b0;
    end else begin
      s_addr <= usb_addr;
      s_din  <= usb_din;
      s_rdn  <= usb_rdn;
      s_wrn  <= usb_wrn;
      s_cen  <= usb_cen;
      s_trig <= usb_trigger;
    end
  end

  usb_edge_det u_edge_det (
    .usb_clk   (usb_clk),
    .reset_i   (reset_i),
    .cen_s     (s_cen),
    .wrn_s     (s_wrn),
    .trig_s    (s_trig),
    .cen_rise  (cen_rise),
    .wrn_prev  (wrn_prev),
    .trig_rise (trig_rise)
  );

  always_comb begin
    state_nxt = state;
    err_cond  = ~s_cen & ~s_rdn & ~s_wrn;
    if (err_cond) begin
      state_nxt = ST_ERR;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!s_cen && !s_wrn)      state_nxt = ST_WRITE;
          else if (!s_cen && !s_rdn) state_nxt = ST_READ;
        end
        ST_WRITE: if (cen_rise)        state_nxt = ST_IDLE;
        ST_READ:  if (s_cen || s_rdn)  state_nxt = ST_IDLE;
        ST_ERR:   if (s_cen)           state_nxt = ST_IDLE;
        default:                       state_nxt = ST_IDLE;
      endcase
    end
    // A wrn that went high before cen leaves wrn_prev=1, so no strobe.
    wr_fire = (state == ST_WRITE) && cen_rise && !wrn_prev;
  end

  always_ff @(posedge usb_clk or posedge reset_i) begin
    if (reset_i) begin
      state         <= ST_IDLE;
      reg_write     <= 1'b0;
      reg_read      <= 1'b0;
      reg_addrvalid <= 1'b0;
      usb_isout     <= 1'b0;
      usb_dout      <= '0;
      reg_datao     <= '0;
      reg_address   <= '0;
      reg_bytecnt   <= '0;
      trig_pulse    <= 1'b0;
      protocol_err  <= 1'b0;
    end else begin
      state         <= state_nxt;
      reg_write     <= wr_fire;
      reg_read      <= (state_nxt == ST_READ);
      reg_addrvalid <= (state_nxt == ST_READ) || (state_nxt == ST_WRITE) || wr_fire;
      usb_isout     <= (state_nxt == ST_READ);
      trig_pulse    <= trig_rise;

      if (state == ST_READ)
        usb_dout <= reg_datai;

      if ((state_nxt == ST_WRITE) && !s_cen && !s_wrn) begin
        reg_datao   <= s_din;
        reg_address <= s_addr[pADDR_WIDTH-1:pBYTECNT_SIZE];
        reg_bytecnt <= s_addr[pBYTECNT_SIZE-1:0];
      end else if (state_nxt == ST_READ) begin
        reg_address <= s_addr[pADDR_WIDTH-1:pBYTECNT_SIZE];
        reg_bytecnt <= s_addr[pBYTECNT_SIZE-1:0];
      end

      if (state_nxt == ST_ERR)
        protocol_err <= 1'b1;
    end
  end

endmodule
